fp_addsub_sequencer: RTL and testbench

//  Upstream issue stage for the addsub FP unit. Buffers add/sub commands in a small FIFO and drives

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_cmd_fifo.sv | 64 ++++++
 rtl/fp_addsub_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fp_addsub_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types for the FP add/sub issue stage: the buffered command record,
// the mode encoding, and the sequencer state set.
package fp_pkg;

  typedef struct packed {
    logic        mode;
    logic [31:0] op1;
    logic [31:0] op2;
  } fp_cmd_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } seq_state_t;

endpackage

// File: rtl/fp_cmd_fifo.sv
// Command FIFO for the add/sub sequencer. Registered storage, no bypass:
// an entry written on one edge is first visible at the head after that edge.
module fp_cmd_fifo
  import fp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               i_push,
  input  logic                               i_pop,
  input  fp_cmd_t                            i_data,
  output fp_cmd_t                            o_data,
  output logic                               o_full,
  output logic                               o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  fp_cmd_t            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign o_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fp_addsub_sequencer.sv
// Issue stage in front of the addsub FP unit: queues commands, runs one
// operation at a time, and returns each result (or a timeout) on a valid/ready port.
module fp_addsub_sequencer
  import fp_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_mode,
  input  logic [31:0] cmd_op1,
  input  logic [31:0] cmd_op2,
  output logic        add_start,
  output logic        mode,
  output logic [31:0] op1,
  output logic [31:0] op2,
  input  logic [31:0] add_result,
  input  logic        add_done,
  input  logic        add_overflow,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_overflow,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int               CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int               TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  seq_state_t         r_state;
  seq_state_t         w_next_state;
  fp_cmd_t            w_cmd_in;
  fp_cmd_t            w_head;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CNT_W-1:0]   w_fifo_count;
  logic               w_pop;
  logic               w_rsp_free;
  logic               w_load_done;
  logic               w_load_tmo;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_mode;
  logic [31:0]        r_op1;
  logic [31:0]        r_op2;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_result;
  logic               r_rsp_overflow;
  logic               r_rsp_timeout;

  assign w_cmd_in = {cmd_mode, cmd_op1, cmd_op2};

  fp_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_push  (cmd_valid),
    .i_pop   (w_pop),
    .i_data  (w_cmd_in),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // A new op is only popped when its eventual response has somewhere to go.
  assign w_rsp_free   = !r_rsp_valid || rsp_ready;
  assign cmd_ready    = !w_fifo_full;
  assign add_start    = (r_state == ISSUE);
  assign busy         = (r_state != IDLE) || (w_fifo_count != '0);
  assign mode         = r_mode;
  assign op1          = r_op1;
  assign op2          = r_op2;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_result   = r_rsp_result;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_timeout  = r_rsp_timeout;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // add_done is checked before the timeout so a late completion still wins.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_load_done  = 1'b0;
    w_load_tmo   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty && w_rsp_free) begin
          w_pop        = 1'b1;
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        w_next_state = WAIT;
      end
      WAIT: begin
        if (add_done) begin
          w_load_done  = 1'b1;
          w_next_state = IDLE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_load_tmo   = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ISSUE) begin
      r_tmo_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end
  end

  // Operands stay put from one pop to the next so addsub may resample them.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_mode <= 1'b0;
      r_op1  <= '0;
      r_op2  <= '0;
    end else if (w_pop) begin
      r_mode <= w_head.mode;
      r_op1  <= w_head.op1;
      r_op2  <= w_head.op2;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rsp_valid    <= 1'b0;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_timeout  <= 1'b0;
    end else if (w_load_done) begin
      r_rsp_valid    <= 1'b1;
      r_rsp_result   <= add_result;
      r_rsp_overflow <= add_overflow;
      r_rsp_timeout  <= 1'b0;
    end else if (w_load_tmo) begin
      r_rsp_valid    <= 1'b1;
      r_rsp_result   <= '0;
      r_rsp_overflow <= 1'b0;
      r_rsp_timeout  <= 1'b1;
    end else if (r_rsp_valid && rsp_ready) begin
      r_rsp_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Bench for fp_addsub_sequencer: a behavioural addsub with adjustable done delay
// answers from a hand-computed vector table; responses are collected in order.
module tb_fp_addsub_sequencer;
  import fp_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;
  localparam int NVEC       = 6;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_mode = 1'b0;
  logic [31:0] cmd_op1 = '0;
  logic [31:0] cmd_op2 = '0;
  logic        add_start;
  logic        mode;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] add_result;
  logic        add_done;
  logic        add_overflow;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_timeout;
  logic        busy;

  typedef struct {
    logic        mode;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] expResult;
    logic        expOvf;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic        ovf;
    logic        tmo;
  } rsp_t;

  vec_t        vecs [NVEC];
  rsp_t        rspQ [$];
  int          checks = 0;
  int          errors = 0;
  int          startCount = 0;
  int          modelDelay = 3;
  int          modelCnt = 0;
  bit          modelNoDone = 1'b0;
  bit          spuriousDone = 1'b0;
  bit          modelDone = 1'b0;
  logic [31:0] modelResult = '0;
  logic        modelOvf = 1'b0;

  assign add_done     = modelDone | spuriousDone;
  assign add_result   = modelResult;
  assign add_overflow = modelOvf;

  fp_addsub_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_op1      (cmd_op1),
    .cmd_op2      (cmd_op2),
    .add_start    (add_start),
    .mode         (mode),
    .op1          (op1),
    .op2          (op2),
    .add_result   (add_result),
    .add_done     (add_done),
    .add_overflow (add_overflow),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .rsp_timeout  (rsp_timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Falling-edge observer: records handshaken responses and plays the addsub unit.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        r.result = rsp_result;
        r.ovf    = rsp_overflow;
        r.tmo    = rsp_timeout;
        rspQ.push_back(r);
      end
      modelDone = 1'b0;
      if (!n_rst) begin
        modelCnt = 0;
      end else begin
        if (modelCnt > 0) begin
          modelCnt--;
          if (modelCnt == 0) modelDone = 1'b1;
        end
        if (add_start) begin
          startCount++;
          modelResult = 32'hDEADBEEF;
          modelOvf    = 1'b0;
          for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].mode == mode && vecs[i].op1 == op1 && vecs[i].op2 == op2) begin
              modelResult = vecs[i].expResult;
              modelOvf    = vecs[i].expOvf;
            end
          end
          if (!modelNoDone) modelCnt = modelDelay;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic m, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_op1   = a;
    cmd_op2   = b;
    while (!cmd_ready && guard < 200) begin
      tick(1);
      guard++;
    end
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (rspQ.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    checkOutput(name, rspQ.size(), n);
  endtask

  task automatic popRsp(output rsp_t r);
    if (rspQ.size() > 0) begin
      r = rspQ.pop_front();
    end else begin
      r.result = 32'hFFFFFFFF;
      r.ovf    = 1'b1;
      r.tmo    = 1'b1;
    end
  endtask

  task automatic checkRsp(input string tag, input int idx);
    rsp_t r;
    popRsp(r);
    checkOutput({tag, " result"}, r.result, vecs[idx].expResult);
    checkOutput({tag, " overflow"}, r.ovf, vecs[idx].expOvf);
    checkOutput({tag, " timeout"}, r.tmo, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " cmd_ready"}, cmd_ready, 1);
    checkOutput({tag, " ctrl outs"}, {add_start, mode, rsp_valid, rsp_overflow, rsp_timeout, busy}, 0);
    checkOutput({tag, " op1"}, op1, 0);
    checkOutput({tag, " op2"}, op2, 0);
    checkOutput({tag, " rsp_result"}, rsp_result, 0);
  endtask

  initial begin
    int   s0;
    int   c;

    vecs[0] = '{MODE_ADD, 32'h41480000, 32'h418C0000, 32'h41F00000, 1'b0};
    vecs[1] = '{MODE_ADD, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0};
    vecs[2] = '{MODE_SUB, 32'h40000000, 32'h3F800000, 32'h3F800000, 1'b0};
    vecs[3] = '{MODE_ADD, 32'h3FC00000, 32'h3F000000, 32'h40000000, 1'b0};
    vecs[4] = '{MODE_SUB, 32'h41F00000, 32'h41480000, 32'h418C0000, 1'b0};
    vecs[5] = '{MODE_ADD, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1};

    #3;
    checkResetOutputs("t1 reset");
    #9 n_rst = 1'b1;
    tick(2);

    $display("[TB] single add");
    modelDelay = 3;
    s0 = startCount;
    applyStimulus(vecs[0].mode, vecs[0].op1, vecs[0].op2);
    waitRsp(1, 50, "t2 rsp count");
    tick(3);
    checkOutput("t2 start pulses", startCount - s0, 1);
    checkRsp("t2", 0);

    $display("[TB] fill FIFO");
    modelDelay = 10;
    s0 = startCount;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].mode, vecs[i].op1, vecs[i].op2);
    end
    checkOutput("t3 cmd_ready when full", cmd_ready, 0);
    checkOutput("t3 busy", busy, 1);
    waitRsp(5, 300, "t3 rsp count");
    tick(2);
    checkOutput("t3 start pulses", startCount - s0, 5);
    for (int i = 0; i < 5; i++) begin
      checkRsp($sformatf("t3 rsp%0d", i), i);
    end

    $display("[TB] backpressure");
    rsp_ready = 1'b0;
    modelDelay = 3;
    s0 = startCount;
    applyStimulus(vecs[1].mode, vecs[1].op1, vecs[1].op2);
    applyStimulus(vecs[2].mode, vecs[2].op1, vecs[2].op2);
    c = 0;
    while (!rsp_valid && c < 50) begin
      tick(1);
      c++;
    end
    checkOutput("t4 first valid", rsp_valid, 1);
    tick(10);
    checkOutput("t4 held valid", rsp_valid, 1);
    checkOutput("t4 held result", rsp_result, vecs[1].expResult);
    checkOutput("t4 starts while held", startCount - s0, 1);
    checkOutput("t4 nothing consumed", rspQ.size(), 0);
    rsp_ready = 1'b1;
    waitRsp(2, 50, "t4 rsp count");
    checkOutput("t4 starts after release", startCount - s0, 2);
    checkRsp("t4 rsp0", 1);
    checkRsp("t4 rsp1", 2);
    tick(3);

    $display("[TB] timeout");
    rsp_ready = 1'b0;
    modelNoDone = 1'b1;
    applyStimulus(vecs[3].mode, vecs[3].op1, vecs[3].op2);
    c = 0;
    while (!add_start && c < 20) begin
      tick(1);
      c++;
    end
    checkOutput("t5 issue seen", add_start, 1);
    tick(1);
    c = 0;
    while (!rsp_valid && c < 100) begin
      tick(1);
      c++;
    end
    checkOutput("t5 timeout latency", c, TIMEOUT);
    checkOutput("t5 rsp_timeout", rsp_timeout, 1);
    checkOutput("t5 rsp_result", rsp_result, 0);
    checkOutput("t5 rsp_overflow", rsp_overflow, 0);
    rsp_ready = 1'b1;
    tick(2);
    rspQ.delete();
    modelNoDone = 1'b0;
    modelDelay = 2;
    applyStimulus(vecs[4].mode, vecs[4].op1, vecs[4].op2);
    waitRsp(1, 50, "t5 next rsp count");
    checkRsp("t5 next", 4);
    tick(2);

    $display("[TB] reset in WAIT and stray add_done");
    modelNoDone = 1'b1;
    applyStimulus(vecs[0].mode, vecs[0].op1, vecs[0].op2);
    tick(4);
    checkOutput("t6 busy before reset", busy, 1);
    #2 n_rst = 1'b0;
    #1;
    checkResetOutputs("t6 reset");
    @(negedge clk);
    n_rst = 1'b1;
    modelNoDone = 1'b0;
    tick(20);
    checkOutput("t6 no rsp after reset", rspQ.size(), 0);
    checkOutput("t6 idle after reset", {rsp_valid, busy, cmd_ready}, 3'b001);
    s0 = startCount;
    spuriousDone = 1'b1;
    tick(2);
    spuriousDone = 1'b0;
    tick(3);
    checkOutput("t6 stray done ignored", {rsp_valid, busy}, 2'b00);
    checkOutput("t6 stray no rsp", rspQ.size(), 0);
    checkOutput("t6 stray no start", startCount - s0, 0);
    modelDelay = 1;
    applyStimulus(vecs[5].mode, vecs[5].op1, vecs[5].op2);
    waitRsp(1, 50, "t6 final rsp count");
    checkRsp("t6 final", 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
